// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that turns a length-prefixed byte stream into 32-bit
// instruction-memory writes. Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 65536
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_byte,
  output logic                  out_ready,
  output logic                  out_we,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [31:0]           out_data,
  output logic                  out_busy,
  output logic                  out_done,
  output logic                  out_error,
  output logic                  out_cpu_rst_n
);

  // One extra bit so that a count equal to DEPTH terminates without wrapping.
  localparam int          CW      = ADDR_WIDTH + 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_HDR_HI, S_HDR_LO, S_DATA, S_DONE, S_ERROR
  } state_t;
`endif

  state_t          state_reg;
  logic [7:0]      hdr_hi_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   idx_reg;
  logic [1:0]      lane_reg;
  logic [23:0]     partial_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_reg;
`endif

  logic            accept;
  logic [15:0]     hdr_count;
  logic [31:0]     word;
  logic [CW-1:0]   idx_inc;
  logic            last_word;
  logic            count_zero;
  logic            count_over;

  assign accept     = in_valid & out_ready;
  assign hdr_count  = {hdr_hi_reg, in_byte};
  assign word       = {partial_reg, in_byte};
  assign idx_inc    = idx_reg + CW'(1);
  assign last_word  = (idx_inc == count_reg);
  assign count_zero = (hdr_count == 16'd0);
  assign count_over = ({16'd0, hdr_count} > DEPTH_U);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_HDR_HI;
      hdr_hi_reg    <= '0;
      count_reg     <= '0;
      idx_reg       <= '0;
      lane_reg      <= '0;
      partial_reg   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_reg      <= '0;
`endif
      out_ready     <= 1'b0;
      out_we        <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
      out_busy      <= 1'b0;
      out_done      <= 1'b0;
      out_error     <= 1'b0;
      out_cpu_rst_n <= 1'b0;
    end else begin
      out_we <= 1'b0;
      case (state_reg)
        S_HDR_HI: begin
          // Ready comes up one cycle after reset release, while already in HDR_HI.
          out_ready <= 1'b1;
          if (accept) begin
            hdr_hi_reg <= in_byte;
            state_reg  <= S_HDR_LO;
          end
        end

        S_HDR_LO: begin
          if (accept) begin
            count_reg <= CW'(hdr_count);
            idx_reg   <= '0;
            lane_reg  <= '0;
            if (count_zero) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_reg <= S_CSUM;
              out_busy  <= 1'b1;
`else
              state_reg     <= S_DONE;
              out_done      <= 1'b1;
              out_cpu_rst_n <= 1'b1;
              out_ready     <= 1'b0;
`endif
            end else if (count_over) begin
              state_reg <= S_ERROR;
              out_error <= 1'b1;
              out_ready <= 1'b0;
            end else begin
              state_reg <= S_DATA;
              out_busy  <= 1'b1;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            lane_reg    <= lane_reg + 2'd1;
            partial_reg <= word[23:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_reg    <= csum_reg ^ in_byte;
`endif
            if (lane_reg == 2'd3) begin
              out_we   <= 1'b1;
              out_addr <= idx_reg[ADDR_WIDTH-1:0];
              out_data <= word;
              idx_reg  <= idx_inc;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_reg <= S_CSUM;
`else
                state_reg     <= S_DONE;
                out_done      <= 1'b1;
                out_cpu_rst_n <= 1'b1;
                out_ready     <= 1'b0;
                out_busy      <= 1'b0;
`endif
              end
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            out_ready <= 1'b0;
            out_busy  <= 1'b0;
            if (in_byte == csum_reg) begin
              state_reg     <= S_DONE;
              out_done      <= 1'b1;
              out_cpu_rst_n <= 1'b1;
            end else begin
              state_reg <= S_ERROR;
              out_error <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          out_ready <= 1'b0;
        end

        S_ERROR: begin
          out_ready <= 1'b0;
        end

        default: begin
          state_reg     <= S_ERROR;
          out_error     <= 1'b1;
          out_ready     <= 1'b0;
          out_busy      <= 1'b0;
          out_cpu_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule
